// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential subtractor datapath.
// Holds the field widths, the saturation constants, the FSM state encoding
// and the bundle passed from the alignment stage to the top-level FSM.
package fp32_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  // Output of the alignment stage. X is the operand with the larger
  // magnitude; mant_y is already shifted into X's exponent frame.
  typedef struct packed {
    logic              special;
    logic [31:0]       special_res;
    logic              sign_x;
    logic              sub;
    logic [EXP_W-1:0]  exp_x;
    logic [MANT_W:0]   mant_x;
    logic [MANT_W:0]   mant_y;
  } align_t;

endpackage

// File: rtl/fp32_align.sv
// Combinational alignment stage of the FP32 subtractor.
// Compares magnitudes and swaps so X is the larger, inserts hidden bits
// (exponent 0 is flushed to zero), right-shifts Y by the exponent difference
// with truncation, and classifies NaN/infinity operands.
// Ports:
//   op_a  in  32  first addend (minuend)
//   op_b  in  32  second addend (subtrahend with sign already inverted)
//   al    out     aligned operands and special-case result
module fp32_align
  import fp32_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output align_t      al
);

  logic             a_is_x;
  logic [31:0]      x;
  logic [31:0]      y;
  logic [EXP_W-1:0] exp_diff;
  logic [MANT_W:0]  mant_y_full;
  logic             nan_a, nan_b, inf_a, inf_b;

  always_comb begin
    // Ties pick op_a; either choice yields the same sum.
    a_is_x = (op_a[30:0] >= op_b[30:0]);
    x      = a_is_x ? op_a : op_b;
    y      = a_is_x ? op_b : op_a;

    exp_diff    = x[30:23] - y[30:23];
    mant_y_full = (y[30:23] != '0) ? {1'b1, y[22:0]} : '0;

    al.sign_x = x[31];
    al.sub    = x[31] ^ y[31];
    al.exp_x  = x[30:23];
    al.mant_x = (x[30:23] != '0) ? {1'b1, x[22:0]} : '0;
    al.mant_y = (exp_diff >= 8'd24) ? '0 : (mant_y_full >> exp_diff);

    nan_a = (&op_a[30:23]) && (op_a[22:0] != '0);
    nan_b = (&op_b[30:23]) && (op_b[22:0] != '0);
    inf_a = (&op_a[30:23]) && (op_a[22:0] == '0);
    inf_b = (&op_b[30:23]) && (op_b[22:0] == '0);

    al.special     = nan_a || nan_b || inf_a || inf_b;
    al.special_res = '0;
    if (nan_a || nan_b)
      al.special_res = QNAN;
    else if (inf_a && inf_b && (op_a[31] != op_b[31]))
      al.special_res = QNAN;
    else if (inf_a)
      al.special_res = {op_a[31], 8'hFF, 23'h0};
    else if (inf_b)
      al.special_res = {op_b[31], 8'hFF, 23'h0};
  end

endmodule

// File: rtl/fp32_sub_seq.sv
// Multi-cycle FP32 subtractor: result = a - b, truncating, denormals flushed.
// The subtrahend's sign is flipped on capture and the rest is an addition.
// The normalizer moves the sum one bit per cycle in NORM.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   a, b, in_valid       operands and their valid; in_ready high in IDLE only
//   result               FP32 difference
//   overflow             exponent saturated to 255 (inf/NaN result)
//   underflow            nonzero result flushed to zero
//   out_valid, out_ready result handshake
module fp32_sub_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t state, state_next;

  logic [31:0]        op_a, op_b;
  align_t             al;
  logic               sign_r, sub_r;
  logic [MANT_W:0]    mant_x_r, mant_y_r;
  logic signed [9:0]  exp_r;
  logic [MANT_W+1:0]  sum_r;

  fp32_align u_align (
    .op_a (op_a),
    .op_b (op_b),
    .al   (al)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (in_valid) state_next = ALIGN;
      ALIGN: state_next = al.special ? DONE : ADD;
      ADD:   state_next = NORM;
      NORM: begin
        if (sum_r == '0)
          state_next = DONE;
        else if (sum_r[MANT_W+1] || !sum_r[MANT_W])
          state_next = NORM;
        else
          state_next = DONE;
      end
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= a;
            op_b <= {~b[31], b[30:0]};
          end
        end
        ALIGN: begin
          if (al.special) begin
            result    <= al.special_res;
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end
          sign_r   <= al.sign_x;
          sub_r    <= al.sub;
          exp_r    <= {2'b00, al.exp_x};
          mant_x_r <= al.mant_x;
          mant_y_r <= al.mant_y;
        end
        ADD: begin
          sum_r <= sub_r ? ({1'b0, mant_x_r} - {1'b0, mant_y_r})
                         : ({1'b0, mant_x_r} + {1'b0, mant_y_r});
        end
        NORM: begin
          if (sum_r == '0) begin
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else if (sum_r[MANT_W+1]) begin
            sum_r <= sum_r >> 1;
            exp_r <= exp_r + 10'sd1;
          end else if (!sum_r[MANT_W]) begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - 10'sd1;
          end else if (exp_r >= 10'sd255) begin
            result    <= {sign_r, 8'hFF, 23'h0};
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end else if (exp_r <= 10'sd0) begin
            result    <= {sign_r, 31'h0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
          end else begin
            result    <= {sign_r, exp_r[7:0], sum_r[MANT_W-1:0]};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_sub_seq.sv
// Scoreboard bench for fp32_sub_seq: directed vectors with hand-computed
// results; the driver queues expectations, the monitor checks on handshake.
module tb_fp32_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        overflow, underflow;
  logic        out_valid;
  logic        out_ready;

  fp32_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  // Monitor: latch the cycle out_valid rises, compare on handshake.
  logic  prev_valid = 1'b0;
  int    rise_cyc = 0;
  exp_t  e;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %08h expected none", result);
        end else begin
          e = sb.pop_front();
          chk({e.nm, ".result"}, result, e.res);
          chk({e.nm, ".overflow"}, {31'b0, overflow}, {31'b0, e.ov});
          chk({e.nm, ".underflow"}, {31'b0, underflow}, {31'b0, e.uf});
          chk({e.nm, ".latency"}, rise_cyc - e.acc, e.lat);
        end
      end
    end
    prev_valid = out_valid && !rst;
  end

  task automatic wait_ready(input string nm);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s.in_ready_timeout: got 0 expected 1", nm);
    end
  endtask

  task automatic send(input string nm, input logic [31:0] ta, input logic [31:0] tb_op,
                      input logic [31:0] res, input logic ov, input logic uf,
                      input int lat, input bit expect_out);
    exp_t x;
    wait_ready(nm);
    a        = ta;
    b        = tb_op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (expect_out) begin
      x.res = res; x.ov = ov; x.uf = uf; x.lat = lat; x.acc = cyc; x.nm = nm;
      sb.push_back(x);
    end
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s.drain_timeout: got %0d pending expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.result", result, 32'h0);
    chk("reset.flags", {30'b0, overflow, underflow}, 32'h0);
    chk("reset.out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.in_ready", {31'b0, in_ready}, 32'h1);

    send("cancel_3m1",   32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 3, 1);
    send("opp_sign",     32'h3F800000, 32'hBF800000, 32'h40000000, 0, 0, 4, 1);
    send("exact_zero",   32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0, 3, 1);
    send("renorm",       32'h3FC00000, 32'h3FA00000, 32'h3E800000, 0, 0, 5, 1);
    send("overflow",     32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1, 0, 4, 1);
    send("inf_m_inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0, 1, 1);
    send("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, 0, 1, 1);
    send("inf_m_one",    32'h7F800000, 32'h3F800000, 32'h7F800000, 1, 0, 1, 1);
    send("one_m_inf",    32'h3F800000, 32'h7F800000, 32'hFF800000, 1, 0, 1, 1);
    send("shift24",      32'h4B800000, 32'h3F800000, 32'h4B800000, 0, 0, 3, 1);
    send("shift23_trunc",32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 0, 0, 4, 1);
    send("underflow",    32'h00C00000, 32'h00A00000, 32'h00000000, 0, 1, 5, 1);
    send("denorm_flush", 32'h00000001, 32'h00000000, 32'h00000000, 0, 0, 3, 1);
    send("neg_result",   32'h3F800000, 32'h40400000, 32'hC0000000, 0, 0, 3, 1);
    drain("directed");

    // Back-pressure: result must sit still while out_ready is low.
    out_ready = 1'b0;
    send("hold", 32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 3, 1);
    begin
      int guard = 0;
      while (!out_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold.result", result, 32'h40000000);
      chk("hold.in_ready", {31'b0, in_ready}, 32'h0);
      chk("hold.out_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain("hold");
    @(negedge clk);
    chk("hold.valid_drop", {31'b0, out_valid}, 32'h0);

    // Abort during NORM of 1.5 - 1.25; nothing may be emitted.
    send("abort", 32'h3FC00000, 32'h3FA00000, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.in_ready_in_rst", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.in_ready_after", {31'b0, in_ready}, 32'h1);
    chk("abort.result_reset", result, 32'h0);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort.no_output", seen, 32'h0);
    end

    send("after_abort", 32'h3FC00000, 32'h3FA00000, 32'h3E800000, 0, 0, 5, 1);
    drain("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
